// File: rtl/bcd_time_count_p.sv
// 24-hour BCD time-of-day counter with a programmable one-second prescaler,
// run/pause control, a validated synchronous time load, 12/24-hour display
// mapping with a PM flag, and one-cycle second / day-wrap / load-error strobes.
// All internal state is kept in 24-hour BCD; only the hour display is remapped.
module bcd_time_count_p #(
   parameter int TICK_DIV = 1,
   parameter int PRESC_W  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       mode_12h,
   input  logic       load,
   input  logic [7:0] ld_hr,
   input  logic [7:0] ld_min,
   input  logic [7:0] ld_sec,
   output logic [3:0] ms_hr,
   output logic [3:0] ls_hr,
   output logic [3:0] ms_min,
   output logic [3:0] ls_min,
   output logic [3:0] ms_sec,
   output logic [3:0] ls_sec,
   output logic       pm,
   output logic       sec_tick,
   output logic       day_wrap,
   output logic       load_err
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   // Time registers, 24-hour BCD digits.
   logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
   logic [PRESC_W-1:0] presc;

   // Successor time and wrap flag.
   logic [3:0] n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u;
   logic       n_wrap;
   logic       terminal;
   logic       ld_ok;

   assign terminal = (presc == PRESC_LAST);

   // A load is accepted only if every digit is a legal time digit.
   assign ld_ok = (ld_hr[3:0]  <= 4'd9) && (ld_hr[7:4]  <= 4'd2) &&
                  !((ld_hr[7:4] == 4'd2) && (ld_hr[3:0] > 4'd3)) &&
                  (ld_min[3:0] <= 4'd9) && (ld_min[7:4] <= 4'd5) &&
                  (ld_sec[3:0] <= 4'd9) && (ld_sec[7:4] <= 4'd5);

   // Compute the time one second later, digit by digit with BCD carries.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      n_sec_u = sec_u + 4'd1;
      n_sec_t = sec_t;
      n_min_u = min_u;
      n_min_t = min_t;
      n_hr_u  = hr_u;
      n_hr_t  = hr_t;
      n_wrap  = 1'b0;
      if (sec_u == 4'd9) begin
         n_sec_u = 4'd0;
         if (sec_t != 4'd5) begin
            n_sec_t = sec_t + 4'd1;
         end else begin
            n_sec_t = 4'd0;
            if (min_u != 4'd9) begin
               n_min_u = min_u + 4'd1;
            end else begin
               n_min_u = 4'd0;
               if (min_t != 4'd5) begin
                  n_min_t = min_t + 4'd1;
               end else begin
                  n_min_t = 4'd0;
                  if ((hr_t == 4'd2) && (hr_u == 4'd3)) begin
                     n_hr_t = 4'd0;
                     n_hr_u = 4'd0;
                     n_wrap = 1'b1;
                  end else if (hr_u == 4'd9) begin
                     n_hr_u = 4'd0;
                     n_hr_t = hr_t + 4'd1;
                  end else begin
                     n_hr_u = hr_u + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Prescaler, time registers and strobes; load has priority over the advance.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         hr_t     <= 4'd0;
         hr_u     <= 4'd0;
         min_t    <= 4'd0;
         min_u    <= 4'd0;
         sec_t    <= 4'd0;
         sec_u    <= 4'd0;
         presc    <= '0;
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
         load_err <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            if (ld_ok) begin
               hr_t  <= ld_hr[7:4];
               hr_u  <= ld_hr[3:0];
               min_t <= ld_min[7:4];
               min_u <= ld_min[3:0];
               sec_t <= ld_sec[7:4];
               sec_u <= ld_sec[3:0];
               presc <= '0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (run) begin
            if (terminal) begin
               presc    <= '0;
               hr_t     <= n_hr_t;
               hr_u     <= n_hr_u;
               min_t    <= n_min_t;
               min_u    <= n_min_u;
               sec_t    <= n_sec_t;
               sec_u    <= n_sec_u;
               sec_tick <= 1'b1;
               day_wrap <= n_wrap;
            end else begin
               presc <= presc + PRESC_W'(1);
            end
         end
      end
   end

   // Display mapping: 24h passes through; 12h maps 00->12 and 13-23 -> 01-11 in BCD.
   always_comb begin
      ms_hr = hr_t;
      ls_hr = hr_u;
      if (mode_12h) begin
         if ((hr_t == 4'd0) && (hr_u == 4'd0)) begin
            ms_hr = 4'd1;
            ls_hr = 4'd2;
         end else if ((hr_t == 4'd1) && (hr_u >= 4'd3)) begin
            ms_hr = 4'd0;
            ls_hr = hr_u - 4'd2;
         end else if ((hr_t == 4'd2) && (hr_u <= 4'd1)) begin
            ms_hr = 4'd0;
            ls_hr = hr_u + 4'd8;
         end else if (hr_t == 4'd2) begin
            ms_hr = 4'd1;
            ls_hr = hr_u - 4'd2;
         end
      end
   end

   assign pm     = (hr_t == 4'd2) || ((hr_t == 4'd1) && (hr_u >= 4'd2));
   assign ms_min = min_t;
   assign ls_min = min_u;
   assign ms_sec = sec_t;
   assign ls_sec = sec_u;

endmodule
